// File: rtl/timer_dev.sv
`default_nettype none
// ============================================================================
// Module   : timer_dev
// Purpose  : Memory-mapped countdown timer and CPU interrupt source.
//            CTRL (addr 0) holds EN/MODE/IM, PRESET (addr 1) is the reload
//            value, COUNT (addr 2) is the read-only live counter. On expiry a
//            pending flag is set and, when IM=1, drives the registered irq.
// Revision : 1.0 - initial release
// Macro    : TIMER_AUTORELOAD_EN - when defined, MODE=01 reloads PRESET after
//            each expiry and irq is a one-cycle pulse. When undefined, every
//            MODE value behaves as one-shot (MODE bits still store/read back).
// Ports    :
//   clk     in   1  system clock, all state updates on posedge
//   reset   in   1  synchronous active-high reset
//   addr    in   2  word select (bus address [3:2])
//   we      in   1  write strobe
//   din     in  32  write data
//   intack  in   1  interrupt acknowledge, clears pending
//   dout    out 32  combinational read data
//   irq     out  1  registered interrupt request
// ============================================================================
module timer_dev #(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  input  logic        intack,
  output logic [31:0] dout,
  output logic        irq
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_CNT    = 2'd2;
  localparam logic [1:0] S_INT    = 2'd3;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  logic [1:0]  state_q,   state_d;
  logic [3:0]  ctrl_q,    ctrl_d;
  logic [31:0] preset_q,  preset_d;
  logic [31:0] count_q,   count_d;
  logic        pending_q, pending_d;
  logic        irq_q,     irq_d;

  // FSM action strobes
  logic w_load;
  logic w_dec;
  logic w_expire;
  logic w_en_clr;
  logic w_reload_clr;

  logic w_ctrl_wr;
  logic w_preset_wr;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ctrl_q    <= 4'd0;
      preset_q  <= PRESET_RST;
      count_q   <= 32'd0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    w_expire     = 1'b0;
    w_en_clr     = 1'b0;
    w_reload_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctrl_q[0]) state_d = S_LOAD;
      end
      S_LOAD: begin
        w_load  = 1'b1;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          w_dec = 1'b1;
        end else begin
          // Also reached with COUNT=0 when PRESET was 0
          w_expire = 1'b1;
          state_d  = S_INT;
        end
      end
      S_INT: begin
`ifdef TIMER_AUTORELOAD_EN
        if (ctrl_q[2:1] == 2'b01) begin
          w_reload_clr = 1'b1;
          state_d      = S_LOAD;
        end else begin
          w_en_clr = 1'b1;
          state_d  = S_IDLE;
        end
`else
        w_en_clr = 1'b1;
        state_d  = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_ctrl_wr   = we && (addr == A_CTRL);
    w_preset_wr = we && (addr == A_PRESET);

    // CPU write overrides the FSM's EN clear on the same edge
    ctrl_d = ctrl_q;
    if (w_en_clr)  ctrl_d[0] = 1'b0;
    if (w_ctrl_wr) ctrl_d    = din[3:0];

    // COUNT only picks up a new PRESET at LOAD
    preset_d = w_preset_wr ? din : preset_q;

    count_d = count_q;
    if (w_load)        count_d = preset_q;
    else if (w_dec)    count_d = count_q - 32'd1;
    else if (w_expire) count_d = 32'd0;

    // Expiry wins over any clear source on the same edge
    pending_d = pending_q;
    if (intack || w_ctrl_wr || w_reload_clr) pending_d = 1'b0;
    if (w_expire)                            pending_d = 1'b1;

    irq_d = pending_d & ctrl_q[3];

    case (addr)
      A_CTRL:   dout = {28'd0, ctrl_q};
      A_PRESET: dout = preset_q;
      A_COUNT:  dout = count_q;
      default:  dout = 32'd0;
    endcase
  end

  assign irq = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_dev.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_dev
// Purpose  : Scoreboard bench for timer_dev. Stimulus pushes expected read
//            data / irq values into a queue; a monitor on the falling edge
//            pops and compares them against the DUT outputs.
// Revision : 1.1
// Macro    : TIMER_AUTORELOAD_EN selects the auto-reload expectations.
// ============================================================================
module tb_timer_dev;

    localparam int C_MIN_CHECKS = 12;

    logic        r_clk;
    logic        r_reset;
    logic [1:0]  r_addr;
    logic        r_we;
    logic [31:0] r_din;
    logic        r_intack;
    logic [31:0] w_dout;
    logic        w_irq;

    timer_dev #(.PRESET_RST(32'h0000_0000)) dut (
        .clk    (r_clk),
        .reset  (r_reset),
        .addr   (r_addr),
        .we     (r_we),
        .din    (r_din),
        .intack (r_intack),
        .dout   (w_dout),
        .irq    (w_irq)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    typedef struct {
        string       name;
        bit          is_irq;
        logic [31:0] exp;
    } item_t;

    item_t r_exp_q[$];
    int    r_n_pass = 0;
    int    r_n_chk  = 0;

    always @(negedge r_clk) begin
        item_t it;
        while (r_exp_q.size() > 0) begin
            it = r_exp_q.pop_front();
            r_n_chk++;
            if (it.is_irq) begin
                if (w_irq === it.exp[0]) r_n_pass++;
                else $display("FAIL %s: irq got %b expected %b", it.name, w_irq, it.exp[0]);
            end else begin
                if (w_dout === it.exp) r_n_pass++;
                else $display("FAIL %s: dout got %h expected %h", it.name, w_dout, it.exp);
            end
        end
    end

    task automatic step();
        @(posedge r_clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge r_clk);
        #1;
        r_we   = 1'b1;
        r_addr = a;
        r_din  = d;
        @(posedge r_clk);
        #1;
        r_we   = 1'b0;
    endtask

    task automatic chk_rd(input logic [1:0] a, input logic [31:0] e, input string n);
        item_t it;
        r_addr    = a;
        it.name   = n;
        it.is_irq = 1'b0;
        it.exp    = e;
        r_exp_q.push_back(it);
    endtask

    task automatic chk_irq(input logic e, input string n);
        item_t it;
        it.name   = n;
        it.is_irq = 1'b1;
        it.exp    = {31'd0, e};
        r_exp_q.push_back(it);
    endtask

    int r_t2_cnt[7] = '{0, 5, 4, 3, 2, 1, 0};
`ifdef TIMER_AUTORELOAD_EN
    int r_t3_cnt[12] = '{0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 3};
    bit r_t3_irq[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    int r_t5_cnt[8]  = '{5, 4, 3, 2, 1, 0, 0, 100};
    bit r_t5_irq[8]  = '{0, 0, 0, 0, 0, 1, 0, 0};
    int r_t5_frz     = 99;
`else
    int r_t3_cnt[12] = '{0, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    bit r_t3_irq[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    int r_t5_cnt[8]  = '{5, 4, 3, 2, 1, 0, 0, 0};
    bit r_t5_irq[8]  = '{0, 0, 0, 0, 0, 1, 1, 1};
    int r_t5_frz     = 0;
`endif

    initial begin
        r_reset  = 1'b1;
        r_addr   = 2'd0;
        r_we     = 1'b0;
        r_din    = 32'd0;
        r_intack = 1'b0;
        repeat (3) step();
        r_reset = 1'b0;

        chk_rd(2'd0, 32'd0, "rst_ctrl");   chk_irq(1'b0, "rst_irq0");
        step(); chk_rd(2'd1, 32'd0, "rst_preset"); chk_irq(1'b0, "rst_irq1");
        step(); chk_rd(2'd2, 32'd0, "rst_count");
        step(); chk_rd(2'd3, 32'd0, "rst_rsvd");
        wr(2'd2, 32'hDEAD_BEEF); chk_rd(2'd2, 32'd0, "count_ro");
        wr(2'd3, 32'h1234_5678); chk_rd(2'd3, 32'd0, "rsvd_ro");

        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        chk_rd(2'd2, 32'd0, "os_e0_count"); chk_irq(1'b0, "os_e0_irq");
        for (int k = 1; k <= 7; k++) begin
            step();
            chk_rd(2'd2, 32'(r_t2_cnt[k-1]), $sformatf("os_e%0d_count", k));
            chk_irq(k == 7, $sformatf("os_e%0d_irq", k));
        end
        step();
        chk_rd(2'd0, 32'h8, "os_e8_ctrl"); chk_irq(1'b1, "os_e8_irq");
        @(negedge r_clk); #1; r_intack = 1'b1;
        step();
        r_intack = 1'b0;
        chk_irq(1'b0, "os_ack_irq"); chk_rd(2'd0, 32'h8, "os_ack_ctrl");

        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk_rd(2'd2, 32'(r_t3_cnt[k-1]), $sformatf("ar_e%0d_count", k));
            chk_irq(r_t3_irq[k-1], $sformatf("ar_e%0d_irq", k));
        end
        wr(2'd0, 32'h0);
        chk_irq(1'b0, "ar_stop_irq"); chk_rd(2'd0, 32'h0, "ar_stop_ctrl");

        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_irq(k == 3, $sformatf("p0_e%0d_irq", k));
        end
        step();
        chk_rd(2'd0, 32'h8, "p0_e4_ctrl"); chk_irq(1'b1, "p0_e4_irq");
        wr(2'd0, 32'h0);
        chk_irq(1'b0, "p0_wrclr_irq"); chk_rd(2'd0, 32'h0, "p0_wrclr_ctrl");

        wr(2'd0, 32'h1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_irq(1'b0, $sformatf("im0_e%0d_irq", k));
        end
        chk_rd(2'd0, 32'h0, "im0_e4_ctrl");
        wr(2'd0, 32'h8);
        chk_irq(1'b0, "im0_wr_irq"); chk_rd(2'd0, 32'h8, "im0_wr_ctrl");

        wr(2'd1, 32'd10);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k >= 2) chk_rd(2'd2, 32'(12 - k), $sformatf("mid_e%0d_count", k));
        end
        step();
        chk_rd(2'd2, 32'd7, "mid_e5_count");
        wr(2'd1, 32'd100);
        chk_rd(2'd2, 32'd6, "mid_e6_count"); chk_irq(1'b0, "mid_e6_irq");
        for (int k = 7; k <= 14; k++) begin
            step();
            chk_rd(2'd2, 32'(r_t5_cnt[k-7]), $sformatf("mid_e%0d_count", k));
            chk_irq(r_t5_irq[k-7], $sformatf("mid_e%0d_irq", k));
        end
        wr(2'd0, 32'h8);
        chk_rd(2'd2, 32'(r_t5_frz), "frz_e15_count"); chk_irq(1'b0, "frz_e15_irq");
        step(); chk_rd(2'd2, 32'(r_t5_frz), "frz_e16_count");
        step(); chk_rd(2'd2, 32'(r_t5_frz), "frz_e17_count");

        wr(2'd1, 32'd6);
        wr(2'd0, 32'h9);
        repeat (4) step();
        chk_rd(2'd2, 32'd4, "rm_e4_count");
        @(negedge r_clk); #1; r_reset = 1'b1;
        step();
        r_reset = 1'b0;
        chk_rd(2'd2, 32'd0, "rm_count"); chk_irq(1'b0, "rm_irq");
        step(); chk_rd(2'd0, 32'd0, "rm_ctrl");
        step(); chk_rd(2'd1, 32'd0, "rm_preset");
        step(); chk_rd(2'd2, 32'd0, "rm_no_restart");
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_irq(k == 3, $sformatf("rm_re_e%0d_irq", k));
        end

        step();
        step();
        $display("%0d/%0d checks passed", r_n_pass, r_n_chk);
        if ((r_n_pass != r_n_chk) || (r_n_chk < C_MIN_CHECKS))
            $display("FAIL summary: %0d of %0d checks passed", r_n_pass, r_n_chk);
        else
            $display("PASS");
        $finish;
    end

endmodule
`default_nettype wire
